// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit, active-low seven-segment scanner with a frame-synchronous value update.
// Optional leading-zero blanking is compiled in by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
  parameter int unsigned DIV         = 1000,
  parameter int unsigned ON_TICKS    = 15,
  parameter int unsigned BLANK_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        load,
  output logic        load_ack,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TMAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        state, state_n;
  logic [1:0]    idx, idx_n;
  logic [PW-1:0] presc, presc_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [15:0]   shadow, shadow_n, pend, pend_n;
  logic          pflag, pflag_n;
  logic          boundary, tick, ack_n;
  logic [6:0]    seg_n;
  logic [3:0]    an_n, digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 2'd0;
      presc <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      presc <= presc_n;
      tcnt  <= tcnt_n;
    end
  end

  // Next-state: prescaled tick drives BLANK/DRIVE phase lengths
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    presc_n  = presc;
    tcnt_n   = tcnt;
    boundary = 1'b0;
    tick     = (presc == PRESC_LAST);
    if (!en) begin
      state_n = IDLE;
      idx_n   = 2'd0;
      presc_n = '0;
      tcnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLANK;
          idx_n   = 2'd0;
          presc_n = '0;
          tcnt_n  = '0;
        end
        BLANK: begin
          presc_n = tick ? '0 : presc + PW'(1);
          if (tick) begin
            if (tcnt == BLANK_LAST) begin
              state_n = DRIVE;
              tcnt_n  = '0;
            end else begin
              tcnt_n = tcnt + TW'(1);
            end
          end
        end
        DRIVE: begin
          presc_n = tick ? '0 : presc + PW'(1);
          if (tick) begin
            if (tcnt == ON_LAST) begin
              state_n  = BLANK;
              idx_n    = idx + 2'd1;
              tcnt_n   = '0;
              boundary = (idx == 2'd3);
            end else begin
              tcnt_n = tcnt + TW'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Pending/shadow update: shadow only moves at a frame boundary or while idle
  always_comb begin
    shadow_n = shadow;
    pend_n   = pend;
    pflag_n  = pflag;
    ack_n    = 1'b0;
    if (boundary) begin
      if (load) begin
        shadow_n = value;
        ack_n    = 1'b1;
        pflag_n  = 1'b0;
      end else if (pflag) begin
        shadow_n = pend;
        ack_n    = 1'b1;
        pflag_n  = 1'b0;
      end
    end else if (load) begin
      pend_n  = value;
      pflag_n = 1'b1;
    end else if (pflag && state == IDLE) begin
      shadow_n = pend;
      ack_n    = 1'b1;
      pflag_n  = 1'b0;
    end
  end

  // Output decode from next-state so registered outputs line up with the FSM
  always_comb begin
    an_n  = 4'hF;
    seg_n = 7'h7F;
    digit = 4'(shadow_n >> {idx_n, 2'b00});
    if (state_n == DRIVE) begin
      an_n  = ~(4'b0001 << idx_n);
      seg_n = decode(digit);
`ifdef SEG7_LZB_EN
      if (idx_n != 2'd0 && (shadow_n >> {idx_n, 2'b00}) == 16'h0000) begin
        an_n  = 4'hF;
        seg_n = 7'h7F;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= 16'h0000;
      pend       <= 16'h0000;
      pflag      <= 1'b0;
      seg        <= 7'h7F;
      an         <= 4'hF;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      shadow     <= shadow_n;
      pend       <= pend_n;
      pflag      <= pflag_n;
      seg        <= seg_n;
      an         <= an_n;
      load_ack   <= ack_n;
      frame_done <= boundary;
    end
  end

endmodule
